mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control sequencer for the MIPS datapath. It decodes the instruction register and steps it through fetch, decode, execute, memory and write-back. On each cycle it drives the 6-bit ALU operation code and the datapath select/enable strobes. It consumes the ALU zero flag to resolve branches and handshakes with the unified instruction/data memory.

## Interface
- `PC_INC`, default 4: byte increment applied to the PC on fetch (ALU add with `alu_src_b`=PC_INC constant).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset. Only one clock; reset polarity and synchronicity are fixed.
- `instr`  in  32: instruction register contents. Valid from DECODE onward.
- `alu_zero`  in  1: ALU zero flag. Sampled in BRANCH.
- `mem_ready`  in  1: memory completion for the current read/write request.
- `alu_op`  out  6: ALU operation code.
- `alu_src_a`  out  1: 0=PC, 1=reg A.
- `alu_src_b`  out  2: 0=reg B, 1=PC_INC, 2=sign-ext imm, 3=zero-ext imm.
- `pc_write`  out  1: PC load enable.
- `pc_src`  out  2: 0=ALU result, 1=branch target register, 2=jump target.
- `ir_write`  out  1: IR load enable.
- `mem_read`  out  1: memory read request.
- `mem_write`  out  1: memory write request.
- `iord`  out  1: address select, 0=PC, 1=ALU out.
- `reg_write`  out  1: register file write enable.
- `reg_dst`  out  1: 0=rt, 1=rd.
- `mem_to_reg`  out  1: 0=ALU out, 1=memory data.
- `illegal`  out  1: sticky flag for an unsupported opcode/funct.
- `state`  out  4: current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT.
- FETCH: asserts `mem_read`, `iord`=0 and ALU PC+PC_INC (`alu_op`=100000, src_a=0, src_b=1). Holds until `mem_ready`. The cycle `mem_ready`=1 asserts `ir_write` and `pc_write` (`pc_src`=0), then goes to DECODE.
- DECODE: computes branch target with ALU PC + sign-ext imm (target register written by the datapath). Dispatch on `instr[31:26]`:
  - 000000 (R-type) -> EXEC_R.
  - 001000/001001/001010/001100/001101/001110 (addi/addiu/slti/andi/ori/xori) -> EXEC_I.
  - 100011/101011 (lw/sw) -> ADDR.
  - 000100/000101/000111 (beq/bne/bgtz) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 011100 with funct 100000/100001 (clz/clo) -> EXEC_R.
  - Anything else -> HALT with `illegal` set.
- EXEC_R: `alu_op` = funct for add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111. clz maps to 011101 and clo to 011100. Any other funct -> HALT/`illegal`. Otherwise goes to WB_R.
- EXEC_I: addi 100000, addiu 100001, slti 101010 (sign-ext). andi 100100, ori 100101, xori 100110 use zero-ext. Goes to WB_I.
- ADDR: alu 100000, src_a=1, src_b=2. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD/MEM_WR: `iord`=1 with the request held until `mem_ready`. MEM_RD then goes to WB_MEM; MEM_WR goes to FETCH.
- WB_R: `reg_write`, `reg_dst`=1. WB_I: `reg_write`, `reg_dst`=0. WB_MEM: `reg_write`, `reg_dst`=0, `mem_to_reg`=1. All go to FETCH.
- BRANCH: beq/bne use alu 011111 on A,B; bgtz uses 001111 on A vs B (B is r0). `pc_write`=1, `pc_src`=1 when taken: beq taken on `alu_zero`=1, bne and bgtz taken on `alu_zero`=0. Goes to FETCH.
- JUMP: `pc_write`, `pc_src`=2, then FETCH.
- HALT: absorbing; all strobes 0. Leaves only via reset.

## Timing
- Reset: state=FETCH, `illegal`=0. Outputs are Moore-decoded from state and IR, except the `mem_ready`-qualified strobes in FETCH. Strobes are 0 in reset. `alu_op`=100000.
- Latency with zero-wait memory (`mem_ready` already high): R/I 4 cycles, lw 5, sw 4, branch 3, jump 3. Each wait cycle adds 1.
- `mem_read`/`mem_write` stay stable while `mem_ready`=0, and drop the cycle after acceptance.
- `pc_write` and `ir_write` are single-cycle pulses.
- Reset mid-instruction aborts immediately. No write strobe is asserted afterward.

## Structure
- Package `mc_ctrl_pkg`: state enum, opcode constants, funct constants, ALU op codes (shared with the ALU).
- Sub-module `mc_alu_op_decode`: combinational mapping from state, opcode and funct to `alu_op` plus a `legal` bit.

## Test plan
- add r3,r1,r2 (0x00221820) with `mem_ready`=1 -> states FETCH,DECODE,EXEC_R,WB_R. `alu_op`=100000 in EXEC_R; `reg_write`, `reg_dst`=1 in cycle 4.
- lw with `mem_ready` low 3 cycles in MEM_RD -> `mem_read`/`iord`=1 held 4 cycles. `reg_write`+`mem_to_reg` one cycle later; total 8 cycles.
- beq with `alu_zero`=1 -> `pc_write`, `pc_src`=1 in BRANCH. With `alu_zero`=0 -> no `pc_write`. bne gives the inverse.
- clz (opcode 011100, funct 100000) -> `alu_op`=011101. ori -> `alu_op`=100101, `alu_src_b`=3.
- Opcode 111111 -> HALT, `illegal`=1 held, no strobes, for 10 cycles. `rst_n` low -> FETCH, `illegal`=0.
- `rst_n` asserted during MEM_WR -> `mem_write` drops asynchronously. Next instruction fetches normally.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer: state
// encoding, opcode/funct fields, ALU operation codes and datapath selects.
// The ALU uses the same operation codes, so keep them in step with it.
package mc_ctrl_pkg;

  // The encoding is visible on the debug `state` port and follows list order.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_ADDR    = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB_R    = 4'd7,
    ST_WB_I    = 4'd8,
    ST_WB_MEM  = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_HALT    = 4'd12
  } state_e;

  // ALU operand B select.
  typedef enum logic [1:0] {
    SRC_B_REG  = 2'd0,
    SRC_B_INC  = 2'd1,
    SRC_B_SEXT = 2'd2,
    SRC_B_ZEXT = 2'd3
  } src_b_e;

  // PC load source.
  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_e;

  // Primary opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  // R-type funct field, instr[5:0].
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // SPECIAL2 funct field.
  localparam logic [5:0] F_CLZ = 6'b100000;
  localparam logic [5:0] F_CLO = 6'b100001;

  // ALU operation codes. R-type operations reuse their funct value.
  localparam logic [5:0] ALU_ADD     = 6'b100000;
  localparam logic [5:0] ALU_ADDU    = 6'b100001;
  localparam logic [5:0] ALU_AND     = 6'b100100;
  localparam logic [5:0] ALU_OR      = 6'b100101;
  localparam logic [5:0] ALU_XOR     = 6'b100110;
  localparam logic [5:0] ALU_SLT     = 6'b101010;
  localparam logic [5:0] ALU_CMP_EQ  = 6'b011111;
  localparam logic [5:0] ALU_CMP_GTZ = 6'b001111;
  localparam logic [5:0] ALU_CLZ     = 6'b011101;
  localparam logic [5:0] ALU_CLO     = 6'b011100;

  // Logical immediates are zero-extended; arithmetic ones sign-extended.
  function automatic logic is_zext_imm(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

  // State following DECODE. R-type funct legality is resolved in EXEC_R,
  // SPECIAL2 funct legality here.
  function automatic state_e decode_dispatch(input logic [5:0] opcode,
                                             input logic [5:0] funct);
    state_e nxt;
    case (opcode)
      OP_RTYPE:                      nxt = ST_EXEC_R;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI:      nxt = ST_EXEC_I;
      OP_LW, OP_SW:                  nxt = ST_ADDR;
      OP_BEQ, OP_BNE, OP_BGTZ:       nxt = ST_BRANCH;
      OP_J:                          nxt = ST_JUMP;
      OP_SPECIAL2:
        nxt = ((funct == F_CLZ) || (funct == F_CLO)) ? ST_EXEC_R : ST_HALT;
      default:                       nxt = ST_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// Combinational ALU operation decode for the control sequencer. Maps the
// current state plus opcode/funct to the ALU operation code and reports
// whether the instruction is one the datapath supports.
import mc_ctrl_pkg::*;

module mc_alu_op_decode (
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_op,
  output logic       legal
);

  logic [5:0] r_op;
  logic       r_legal;
  logic [5:0] s2_op;
  logic       s2_legal;
  logic [5:0] imm_op;

  // Per-format operation lookup, then select by state.
  // NOTE: every output of a combinational block gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    r_op     = ALU_ADD;
    r_legal  = 1'b1;
    s2_op    = ALU_ADD;
    s2_legal = 1'b1;
    imm_op   = ALU_ADD;
    alu_op   = ALU_ADD;
    legal    = 1'b1;

    case (funct)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV:
        r_op = funct;
      default:
        r_legal = 1'b0;
    endcase

    case (funct)
      F_CLZ:   s2_op = ALU_CLZ;
      F_CLO:   s2_op = ALU_CLO;
      default: s2_legal = 1'b0;
    endcase

    case (opcode)
      OP_ADDIU: imm_op = ALU_ADDU;
      OP_SLTI:  imm_op = ALU_SLT;
      OP_ANDI:  imm_op = ALU_AND;
      OP_ORI:   imm_op = ALU_OR;
      OP_XORI:  imm_op = ALU_XOR;
      default:  imm_op = ALU_ADD;
    endcase

    case (opcode)
      OP_RTYPE:    legal = r_legal;
      OP_SPECIAL2: legal = s2_legal;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_J:
        legal = 1'b1;
      default:     legal = 1'b0;
    endcase

    case (state)
      ST_EXEC_R: alu_op = (opcode == OP_SPECIAL2) ? s2_op : r_op;
      ST_EXEC_I: alu_op = imm_op;
      ST_BRANCH: alu_op = (opcode == OP_BGTZ) ? ALU_CMP_GTZ : ALU_CMP_EQ;
      default:   alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath. Steps each instruction
// through fetch, decode, execute, memory and write-back, driving the ALU
// operation, operand selects and datapath enables. Outputs are decoded from
// the current state and IR; only the FETCH load strobes (qualified by
// mem_ready) and the branch PC write (qualified by alu_zero) look at inputs.
import mc_ctrl_pkg::*;

module mc_control_fsm #(
  parameter int PC_INC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [5:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [3:0]  state
);

  // The increment itself is a datapath constant selected with alu_src_b=1;
  // the sequencer only guards against a nonsensical value.
  if ((PC_INC <= 0) || ((PC_INC % 4) != 0)) begin : g_bad_pc_inc
    $error("PC_INC must be a positive multiple of 4");
  end

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [5:0] dec_alu_op;
  logic       dec_legal;

  // Register fields and immediates are consumed by the datapath, not here.
  logic       unused_instr_bits;

  src_b_e     src_b_sel;
  pc_src_e    pc_src_sel;
  logic       src_a_sel;
  logic       pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic       iord_s, reg_dst_s, mem_to_reg_s;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  mc_alu_op_decode u_alu_op_decode (
    .state  (state_q),
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // Next-state selection and sticky illegal-instruction flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = decode_dispatch(opcode, funct);
      ST_EXEC_R: state_d = dec_legal ? ST_WB_R : ST_HALT;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_ADDR:   state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR: if (mem_ready) state_d = ST_FETCH;
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP:
                 state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
    // HALT is only ever entered on an unsupported instruction.
    illegal_d = illegal_q | (state_d == ST_HALT);
  end

  // State and illegal flag registers.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath selects and raw enables decoded from the current state.
  always_comb begin
    src_a_sel    = 1'b0;
    src_b_sel    = SRC_B_REG;
    pc_src_sel   = PC_SRC_ALU;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    iord_s       = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        src_b_sel  = SRC_B_INC;
        mem_read_s = 1'b1;
        // IR and PC load on the cycle the memory returns the instruction.
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      ST_DECODE: src_b_sel = SRC_B_SEXT;
      ST_EXEC_R: begin
        src_a_sel = 1'b1;
        src_b_sel = SRC_B_REG;
      end
      ST_EXEC_I: begin
        src_a_sel = 1'b1;
        src_b_sel = is_zext_imm(opcode) ? SRC_B_ZEXT : SRC_B_SEXT;
      end
      ST_ADDR: begin
        src_a_sel = 1'b1;
        src_b_sel = SRC_B_SEXT;
      end
      ST_MEM_RD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      ST_WB_R: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      ST_WB_I: reg_write_s = 1'b1;
      ST_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      ST_BRANCH: begin
        src_a_sel  = 1'b1;
        src_b_sel  = SRC_B_REG;
        pc_src_sel = PC_SRC_BRANCH;
        // beq is taken on equality; bne and bgtz on a non-zero result.
        pc_write_s = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
      end
      ST_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_sel = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  assign alu_op     = dec_alu_op;
  assign alu_src_a  = src_a_sel;
  assign alu_src_b  = src_b_sel;
  assign pc_src     = pc_src_sel;
  assign iord       = iord_s;
  assign reg_dst    = reg_dst_s;
  assign mem_to_reg = mem_to_reg_s;

  // Write/request strobes are forced low while reset is held, so an aborted
  // transfer drops immediately and the FETCH request does not appear early.
  assign pc_write  = pc_write_s  & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign mem_read  = mem_read_s  & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign reg_write = reg_write_s & rst_n;

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Each instruction is expanded into
// a list of per-cycle expected outputs from the instruction class and the
// chosen memory wait counts; every cycle is compared at the falling edge.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic [5:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        illegal;
  logic [3:0]  state;

  mc_control_fsm #(.PC_INC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic       sa;
    logic [1:0] sb;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       io;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    out_t        exp;
  } cyc_t;

  // State numbers in the order the states are listed.
  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3,
                 S_ADDR = 4, S_MEM_RD = 5, S_MEM_WR = 6, S_WB_R = 7,
                 S_WB_I = 8, S_WB_MEM = 9, S_BRANCH = 10, S_JUMP = 11,
                 S_HALT = 12;

  cyc_t cyc_q[$];
  out_t act_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic out_t get_act();
    out_t a;
    a.st  = state;     a.op  = alu_op;    a.sa  = alu_src_a; a.sb = alu_src_b;
    a.pcw = pc_write;  a.pcs = pc_src;    a.irw = ir_write;  a.mr = mem_read;
    a.mw  = mem_write; a.io  = iord;      a.rw  = reg_write; a.rd = reg_dst;
    a.m2r = mem_to_reg; a.ill = illegal;
    return a;
  endfunction

  // Quiet cycle in a given state: ALU add, selects 0, no strobes.
  function automatic out_t blank(input int st);
    out_t e;
    e     = '0;
    e.st  = 4'(st);
    e.op  = 6'b100000;
    return e;
  endfunction

  function automatic out_t reset_exp();
    out_t e;
    e    = blank(S_FETCH);
    e.sb = 2'd1;
    return e;
  endfunction

  function automatic logic r_funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                     6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                     6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                     6'b000111};
  endfunction

  function automatic logic [5:0] imm_alu(input logic [5:0] op);
    case (op)
      6'b001000: return 6'b100000;
      6'b001001: return 6'b100001;
      6'b001010: return 6'b101010;
      6'b001100: return 6'b100100;
      6'b001101: return 6'b100101;
      default:   return 6'b100110;
    endcase
  endfunction

  task automatic push(input logic [31:0] ins, input logic rdy, input logic z,
                      input out_t e);
    cyc_t c;
    c.ins = ins; c.rdy = rdy; c.z = z; c.exp = e;
    cyc_q.push_back(c);
  endtask

  // Expand one instruction into its expected cycles. fw / mwait are the
  // number of not-ready cycles before the fetch / data access completes.
  task automatic model_instr(input logic [31:0] ins, input int fw,
                             input int mwait, input logic z,
                             input int halt_cycles, output bit halted);
    out_t e;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    halted = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      e = blank(S_FETCH); e.sb = 2'd1; e.mr = 1'b1;
      if (i == fw) begin e.irw = 1'b1; e.pcw = 1'b1; end
      push(ins, i == fw, 1'($urandom), e);
    end
    e = blank(S_DECODE); e.sb = 2'd2;
    push(ins, 1'($urandom), 1'($urandom), e);
    if (op == 6'b000000 ||
        (op == 6'b011100 && (fn == 6'b100000 || fn == 6'b100001))) begin
      e = blank(S_EXEC_R); e.sa = 1'b1;
      if (op == 6'b011100)   e.op = (fn == 6'b100000) ? 6'b011101 : 6'b011100;
      else if (r_funct_ok(fn)) e.op = fn;
      push(ins, 1'($urandom), 1'($urandom), e);
      if (op == 6'b011100 || r_funct_ok(fn)) begin
        e = blank(S_WB_R); e.rw = 1'b1; e.rd = 1'b1;
        push(ins, 1'($urandom), 1'($urandom), e);
      end else halted = 1'b1;
    end else if (op inside {6'b001000, 6'b001001, 6'b001010,
                            6'b001100, 6'b001101, 6'b001110}) begin
      e = blank(S_EXEC_I); e.sa = 1'b1; e.op = imm_alu(op);
      e.sb = (op inside {6'b001100, 6'b001101, 6'b001110}) ? 2'd3 : 2'd2;
      push(ins, 1'($urandom), 1'($urandom), e);
      e = blank(S_WB_I); e.rw = 1'b1;
      push(ins, 1'($urandom), 1'($urandom), e);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = blank(S_ADDR); e.sa = 1'b1; e.sb = 2'd2;
      push(ins, 1'($urandom), 1'($urandom), e);
      for (int i = 0; i <= mwait; i++) begin
        e = blank((op == 6'b100011) ? S_MEM_RD : S_MEM_WR); e.io = 1'b1;
        if (op == 6'b100011) e.mr = 1'b1; else e.mw = 1'b1;
        push(ins, i == mwait, 1'($urandom), e);
      end
      if (op == 6'b100011) begin
        e = blank(S_WB_MEM); e.rw = 1'b1; e.m2r = 1'b1;
        push(ins, 1'($urandom), 1'($urandom), e);
      end
    end else if (op inside {6'b000100, 6'b000101, 6'b000111}) begin
      e = blank(S_BRANCH); e.sa = 1'b1; e.pcs = 2'd1;
      e.op  = (op == 6'b000111) ? 6'b001111 : 6'b011111;
      e.pcw = (op == 6'b000100) ? z : !z;
      push(ins, 1'($urandom), z, e);
    end else if (op == 6'b000010) begin
      e = blank(S_JUMP); e.pcw = 1'b1; e.pcs = 2'd2;
      push(ins, 1'($urandom), 1'($urandom), e);
    end else halted = 1'b1;
    if (halted)
      for (int i = 0; i < halt_cycles; i++) begin
        e = blank(S_HALT); e.ill = 1'b1;
        push(ins, 1'($urandom), 1'($urandom), e);
      end
  endtask

  // Drive and check queued cycles; entry point is just after a rising edge.
  task automatic run_queue(input int max_cycles);
    cyc_t c;
    out_t a;
    int   n;
    n = 0;
    act_log.delete();
    while (cyc_q.size() > 0 && n < max_cycles) begin
      c = cyc_q.pop_front();
      instr = c.ins; mem_ready = c.rdy; alu_zero = c.z;
      @(negedge clk);
      a = get_act();
      check("cycle", 32'(a), 32'(c.exp));
      act_log.push_back(a);
      @(posedge clk); #1;
      n++;
    end
    cyc_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'(get_act()), 32'(reset_exp()));
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      check("reset_hold", 32'(get_act()), 32'(reset_exp()));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    int k;
    k  = $urandom_range(0, 19);
    op = 6'($urandom);
    case (k)
      0, 1, 2, 3, 4, 19: begin
        case ($urandom_range(0, 15))
          0: op = 6'b100000; 1: op = 6'b100001; 2: op = 6'b100010;
          3: op = 6'b100011; 4: op = 6'b100100; 5: op = 6'b100101;
          6: op = 6'b100110; 7: op = 6'b100111; 8: op = 6'b101010;
          9: op = 6'b101011; 10: op = 6'b000000; 11: op = 6'b000010;
          12: op = 6'b000011; 13: op = 6'b000100; 14: op = 6'b000110;
          default: op = 6'b000111;
        endcase
        return {6'b000000, 20'($urandom), op};
      end
      5: return {6'b000000, 26'($urandom)};
      6, 7, 8: begin
        case ($urandom_range(0, 5))
          0: op = 6'b001000; 1: op = 6'b001001; 2: op = 6'b001010;
          3: op = 6'b001100; 4: op = 6'b001101; default: op = 6'b001110;
        endcase
        return {op, 26'($urandom)};
      end
      9, 10: return {6'b100011, 26'($urandom)};
      11:    return {6'b101011, 26'($urandom)};
      12:    return {6'b000100, 26'($urandom)};
      13:    return {6'b000101, 26'($urandom)};
      14:    return {6'b000111, 26'($urandom)};
      15:    return {6'b000010, 26'($urandom)};
      16:    return {6'b011100, 20'($urandom), 5'b10000, 1'($urandom)};
      17:    return {6'b011100, 26'($urandom)};
      default: return {op, 26'($urandom)};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int cnt;
    rst_n = 1'b1; instr = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // add r3,r1,r2 with zero-wait memory.
    model_instr(32'h00221820, 0, 0, 1'b0, 0, h);
    check("model_add_len", cyc_q.size(), 4);
    run_queue(100);
    check("add_exec_op", act_log[2].op, 6'b100000);
    check("add_wb_state", act_log[3].st, 4'd7);
    check("add_wb_rw_rd", {act_log[3].rw, act_log[3].rd}, 2'b11);

    // lw with three not-ready cycles in MEM_RD.
    model_instr(32'h8C220004, 0, 3, 1'b0, 0, h);
    check("model_lw_len", cyc_q.size(), 8);
    run_queue(100);
    cnt = 0;
    foreach (act_log[i]) if (act_log[i].mr && act_log[i].io) cnt++;
    check("lw_mem_read_cycles", cnt, 4);
    check("lw_wb", {act_log[7].st, act_log[7].rw, act_log[7].m2r}, {4'd9, 2'b11});

    // beq / bne, both polarities of alu_zero.
    for (int i = 0; i < 4; i++) begin
      model_instr((i < 2) ? 32'h10220003 : 32'h14220003, 0, 0, 1'(i % 2 == 0), 0, h);
      run_queue(100);
      check("branch_pc_write", {act_log[2].pcw, act_log[2].pcs},
            (i == 0 || i == 3) ? 3'b101 : 3'b001);
    end

    // clz and ori.
    model_instr(32'h70201820, 0, 0, 1'b0, 0, h);
    run_queue(100);
    check("clz_op", act_log[2].op, 6'b011101);
    model_instr(32'h34220005, 1, 0, 1'b0, 0, h);
    run_queue(100);
    check("ori_op_srcb", {act_log[3].op, act_log[3].sb}, {6'b100101, 2'd3});

    // Illegal opcode: HALT for 10 cycles, then reset.
    model_instr(32'hFC000000, 0, 0, 1'b0, 10, h);
    check("model_halt_len", cyc_q.size(), 12);
    run_queue(100);
    for (int i = 2; i < 12; i++)
      check("halt_hold", {act_log[i].st, act_log[i].ill, act_log[i].pcw,
                          act_log[i].irw, act_log[i].mr, act_log[i].mw,
                          act_log[i].rw}, {4'd12, 6'b100000});
    do_reset();

    // Reset while a store is waiting in MEM_WR, then a normal fetch.
    model_instr(32'hAC220008, 0, 5, 1'b0, 0, h);
    run_queue(5);
    check("sw_pending_write", {state, mem_write}, {4'd6, 1'b1});
    do_reset();
    model_instr(32'h00221820, 0, 0, 1'b0, 0, h);
    run_queue(100);
    check("post_reset_add_wb", act_log[3].st, 4'd7);

    // Random instruction stream with random memory waits.
    for (int n = 0; n < 250; n++) begin
      model_instr(rand_instr(),
                  ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                  ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                  1'($urandom), $urandom_range(1, 4), h);
      run_queue(1000);
      if (h) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
